// File: rtl/fw_interface_pkg.sv
// Shared types and constants for the command-driven Wishbone B4 initiator:
// response codes, cycle-type encodings, FSM states and burst length helper.
package fw_interface_pkg;

  localparam int BEAT_W = 5;

  typedef enum logic [1:0] {
    RSP_OK      = 2'd0,
    RSP_ERR     = 2'd1,
    RSP_RTY     = 2'd2,
    RSP_TIMEOUT = 2'd3
  } rsp_status_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_BUS,
    S_RETRY,
    S_RESP
  } state_t;

  // A zero length means one beat; anything above the burst limit is clamped.
  function automatic logic [BEAT_W-1:0] burst_len(input logic [BEAT_W-1:0] len,
                                                  input int max_burst);
    if (len == '0) return BEAT_W'(1);
    if (int'(len) > max_burst) return BEAT_W'(max_burst);
    return len;
  endfunction

endpackage

// File: rtl/fw_interface_wb_master_wdog.sv
// Bus watchdog for fw_interface_wb_master: flags the cycle in which the
// bus has gone TIMEOUT_CYCLES cycles without a termination.
module fw_interface_wb_master_wdog #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic count_en,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else if (count_en) cnt <= cnt + 1'b1;
  end

  assign expired = count_en && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/fw_interface_wb_master.sv
// Command-driven Wishbone B4 initiator: single/incrementing-burst reads and
// writes with one status response per command. Optional bus watchdog under
// FW_INTERFACE_WB_MASTER_TIMEOUT_EN.
module fw_interface_wb_master
  import fw_interface_pkg::*;
#(
  parameter int MAX_BURST      = 16,
  parameter int RETRY_LIMIT    = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [3:0]  cmd_sel,
  input  logic [4:0]  cmd_len,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        rd_last,
  output logic        rsp_valid,
  output logic [1:0]  rsp_status,
  output logic [4:0]  rsp_beats,
  output logic        busy,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [1:0]  wb_bte_o,
  output logic [2:0]  wb_cti_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i
);

  localparam int RW = $clog2(RETRY_LIMIT + 1);

  if (MAX_BURST < 1 || MAX_BURST > 16 || (MAX_BURST & (MAX_BURST - 1)) != 0 ||
      RETRY_LIMIT < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("fw_interface_wb_master: illegal parameter value");
  end

  state_t             state, state_nxt;
  rsp_status_t        status_q, status_nxt;
  logic               we_q;
  logic [3:0]         sel_q;
  logic [31:0]        adr_q;
  logic [BEAT_W-1:0]  len_q, beat_q;
  logic [RW-1:0]      rty_q;
  logic               last_beat, timeout;

  assign last_beat = (beat_q + 1'b1) == len_q;

  // cyc stays asserted across write-data stalls once the burst is underway.
  assign wb_cyc_o  = (state == S_BUS) || (state == S_WDATA && beat_q != '0);
  assign wb_stb_o  = (state == S_BUS);
  assign wb_adr_o  = adr_q + {{(30-BEAT_W){1'b0}}, beat_q, 2'b00};
  assign wb_we_o   = we_q;
  assign wb_sel_o  = sel_q;
  assign wb_bte_o  = BTE_LINEAR;
  assign wb_cti_o  = !wb_cyc_o       ? CTI_CLASSIC :
                     (len_q == 5'd1) ? CTI_CLASSIC :
                     last_beat       ? CTI_EOB     : CTI_INCR;
  assign cmd_ready = (state == S_IDLE);
  assign wr_ready  = (state == S_WDATA);
  assign busy      = (state != S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign rsp_status = status_q;
  assign rsp_beats  = beat_q;

`ifdef FW_INTERFACE_WB_MASTER_TIMEOUT_EN
  logic term;
  assign term = wb_ack_i | wb_err_i | wb_rty_i;

  // Clearing whenever cyc is low also covers entry into the write-data state.
  fw_interface_wb_master_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .count_en (wb_cyc_o & ~term),
    .clear    (~wb_cyc_o | term),
    .expired  (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    // NOTE: every comb output gets a default first so no latch is inferred.
    state_nxt  = state;
    status_nxt = status_q;
    unique case (state)
      S_IDLE: if (cmd_valid) begin
        state_nxt  = cmd_we ? S_WDATA : S_BUS;
        status_nxt = RSP_OK;
      end
      S_WDATA: begin
        if (wr_valid) state_nxt = S_BUS;
        else if (timeout) begin
          state_nxt  = S_RESP;
          status_nxt = RSP_TIMEOUT;
        end
      end
      S_BUS: begin
        if (wb_err_i) begin
          state_nxt  = S_RESP;
          status_nxt = RSP_ERR;
        end else if (wb_rty_i) begin
          if (rty_q == RW'(RETRY_LIMIT - 1)) begin
            state_nxt  = S_RESP;
            status_nxt = RSP_RTY;
          end else begin
            state_nxt = S_RETRY;
          end
        end else if (wb_ack_i) begin
          if (last_beat) state_nxt = S_RESP;
          else if (we_q) state_nxt = S_WDATA;
        end else if (timeout) begin
          state_nxt  = S_RESP;
          status_nxt = RSP_TIMEOUT;
        end
      end
      S_RETRY: state_nxt = S_BUS;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= S_IDLE;
      status_q <= RSP_OK;
      we_q     <= 1'b0;
      sel_q    <= '0;
      adr_q    <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      rty_q    <= '0;
      wb_dat_o <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_last  <= 1'b0;
    end else begin
      state    <= state_nxt;
      status_q <= status_nxt;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      unique case (state)
        S_IDLE: if (cmd_valid) begin
          we_q   <= cmd_we;
          sel_q  <= cmd_sel;
          adr_q  <= cmd_adr;
          len_q  <= burst_len(cmd_len, MAX_BURST);
          beat_q <= '0;
          rty_q  <= '0;
        end
        S_WDATA: if (wr_valid) wb_dat_o <= wr_data;
        S_BUS: begin
          if (!wb_err_i && wb_rty_i) begin
            rty_q <= rty_q + 1'b1;
          end else if (!wb_err_i && wb_ack_i) begin
            beat_q <= beat_q + 1'b1;
            rty_q  <= '0;
            if (!we_q) begin
              rd_valid <= 1'b1;
              rd_data  <= wb_dat_i;
              rd_last  <= last_beat;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fw_interface_wb_master.md
Name: fw_interface_wb_master

Overview:
Command-driven Wishbone B4 initiator, the bus-master counterpart to the firmware test interface responder. Testbench or firmware-model logic issues single or incrementing-burst read/write commands through a valid/ready port. The block runs the Wishbone cycles, streams data in and out, and returns one status response per command. It sits on the testbench side of the SoC Wishbone interconnect.

Parameters:
MAX_BURST, 16, maximum beats per command (power of two, ≤16)
RETRY_LIMIT, 4, number of wb_rty_i re-issues of one beat before the command aborts
TIMEOUT_CYCLES, 256, cycles without termination before abort (used only with the optional feature)

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  synchronous active-high reset
cmd_valid/cmd_ready  in/out  1/1  command handshake; transfer when both are high
cmd_we  in  1  1=write, 0=read
cmd_adr  in  32  start byte address, word aligned
cmd_sel  in  4  byte select applied to every beat
cmd_len  in  5  beat count 1..MAX_BURST; 0 is treated as 1
wr_valid/wr_ready  in/out  1/1  write-data handshake, one beat per transfer
wr_data  in  32  write beat data
rd_valid  out  1  one-cycle pulse per read beat; no backpressure
rd_data  out  32  captured wb_dat_i
rd_last  out  1  high with the final successful read beat
rsp_valid  out  1  one-cycle pulse at command end
rsp_status  out  2  0=OK, 1=ERR, 2=RTY_EXHAUSTED, 3=TIMEOUT
rsp_beats  out  5  beats acknowledged
busy  out  1  high from command accept to rsp_valid, inclusive
wb_adr_o, wb_dat_o  out  32 each
wb_sel_o  out  4
wb_we_o, wb_cyc_o, wb_stb_o  out  1 each
wb_bte_o  out  2  always 00 (linear)
wb_cti_o  out  3
wb_dat_i  in  32
wb_ack_i, wb_err_i, wb_rty_i  in  1 each

Behaviour:
- Reset: wb_rst_i is synchronous and active-high. All outputs are 0 on the first edge with reset high, except cmd_ready, which is 1. A reset during any state drops cyc/stb on that edge, discards the command and emits no rsp_valid.
- Interface decision (fixed): single clock wb_clk_i; synchronous active-high reset wb_rst_i.
- States: IDLE, WDATA, BUS, RETRY, RESP.
- IDLE: cmd_ready=1. On cmd_valid, latch the command and clear the beat and retry counters. Next state is WDATA if cmd_we=1, otherwise BUS.
- WDATA: wr_ready=1, cyc is held if the burst has already started, stb=0. On wr_valid, load wb_dat_o and go to BUS.
- BUS: cyc=1, stb=1, adr = base + 4*beat (32-bit wrap), we/sel from the latched command.
- wb_cti_o: 000 when the length is 1; 010 for non-final burst beats; 111 for the final beat.
- Termination priority when inputs coincide: err > rty > ack.
  - ack: beat++, retry count cleared. For reads, rd_valid pulses on the next cycle with the registered data. If this was the last beat, drop cyc/stb and go to RESP. Otherwise go to WDATA (write) or stay in BUS (read, stb held for back-to-back beats).
  - err: drop cyc/stb, go to RESP with status ERR and the beats completed so far.
  - rty: drop cyc/stb for exactly one cycle (RETRY), then re-issue the same beat. The retry count increments on each rty. When it reaches RETRY_LIMIT, go to RESP with status RTY_EXHAUSTED. A retried write reuses wb_dat_o and takes no new wr beat.
- RESP: rsp_valid=1 for one cycle, then IDLE. The earliest next accept is the cycle after RESP.
- Minimum single-read latency: accept to rsp_valid is 3 cycles with a zero-wait slave (accept, BUS+ack, RESP).

Optional Feature:
FW_INTERFACE_WB_MASTER_TIMEOUT_EN
- Defined: a watchdog counts cycles with cyc=1 and no ack/err/rty. It resets on every termination and on WDATA entry. At TIMEOUT_CYCLES it drops cyc/stb and goes to RESP with status TIMEOUT.
- Undefined: no counter; the master waits indefinitely, and status 3 is never produced.

Decomposition:
- Package fw_interface_pkg holds:
  - status codes: RSP_OK, RSP_ERR, RSP_RTY, RSP_TIMEOUT
  - CTI constants: CTI_CLASSIC, CTI_INCR, CTI_EOB
  - BTE_LINEAR
  - the state enumeration
- Sub-module fw_interface_wb_master_wdog holds the timeout counter. It is instantiated only under the macro.

Test Plan:
- Single read 0x0000_0040, slave acks in the first BUS cycle with 0xDEAD_BEEF -> rd_valid with rd_data=0xDEAD_BEEF, rd_last=1, cti=000; rsp OK, rsp_beats=1, three cycles after accept.
- 4-beat write from 0x100, data 1,2,3,4, wr_valid delayed 2 cycles on beat 3 -> adr 0x100/104/108/10C, cti 010,010,010,111, cyc held continuously with stb low during the stall; rsp OK, beats=4.
- 8-beat read with err on beat 5 -> 4 rd_valid pulses, cyc drops the cycle after err, rsp ERR, beats=4, rd_last never asserted.
- Single write, slave asserts rty 4 times -> four stb assertions, each separated by one idle cycle; rsp RTY_EXHAUSTED. Repeat with rty twice then ack -> rsp OK, same wb_dat_o on every attempt.
- With TIMEOUT_EN defined, slave silent -> cyc drops after 256 cycles, rsp TIMEOUT; ack and err asserted together -> treated as err.
- wb_rst_i asserted mid-burst on beat 2 -> cyc/stb low on that edge, no rsp_valid, cmd_ready=1; next command executes normally.
